spi_frame_decoder: RTL and testbench
====================================

# spi_frame_decoder

Downstream consumer of the SPI byte-slave on the stepper controller. Assembles the byte stream received during one slave-select assertion into register read/write commands for the stepper register bank, and drives the byte that the SPI slave loads for transmission. Output side connects to the register bank (write strobe, read strobe, 1-cycle read data).

## Interface
Parameters:
- ADDR_BITS, 7: register address width, taken from cmd byte bits [6:0]
- STATUS_ID, 6'b100101: constant low 6 bits of the status byte

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ss  in  1  raw slave-select pin (active low), asynchronous
- rx_valid  in  1  one-cycle pulse from SPI slave's done
- rx_data  in  8  received byte, valid with rx_valid
- tx_data  out  8  byte for SPI slave's din; registered
- reg_addr  out  ADDR_BITS  register address
- reg_wdata  out  32  write data
- reg_we  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  32  read data, valid 1 cycle after reg_rd
- err_clr  in  1  clears sticky error flags
- frame_err  out  1  sticky: frame ended short
- crc_err  out  1  sticky: checksum mismatch (only with CHECKSUM_EN)

## Operation
- ss double-flop synchronised; ss_s high = no frame. ss_s high in any state -> IDLE, byte counter 0, tx_data = status.
- Status byte = {frame_err, crc_err, STATUS_ID}.
- Byte 0 = cmd: bit7=1 write, bit7=0 read; bits[6:0] -> reg_addr (latched).
- Write frame: cmd, D3, D2, D1, D0 (MSB first). After 4th data byte, reg_wdata = {D3..D0}, reg_we pulses once.
- Read frame: cmd, turnaround, R3, R2, R1, R0. Master byte values after cmd ignored. Slave returns status during byte 1.
- States: IDLE -> (cmd write) WR_DATA -> [WR_CRC] -> DRAIN; IDLE -> (cmd read) RD_ISSUE -> RD_WAIT -> RD_DATA -> DRAIN. DRAIN ignores all rx_valid until ss_s high.
- RD_ISSUE: reg_rd pulse cycle after cmd rx_valid; RD_WAIT: capture reg_rdata into 32-bit shadow, tx_data = shadow[31:24]. On rx_valid of bytes 1,2,3: tx_data <- [23:16], [15:8], [7:0]; on byte 4: tx_data <- status, -> DRAIN after byte 5.
- Short frame: ss_s rises after >=1 byte but before frame complete -> frame_err set, no reg_we. Zero-byte frame: no error.
- err_clr and an error event same cycle: set wins.

## Timing
- Reset values: tx_data = {2'b00, STATUS_ID}, reg_addr = 0, reg_wdata = 0, reg_we = 0, reg_rd = 0, frame_err = 0, crc_err = 0; state IDLE.
- Reset mid-frame: returns to IDLE immediately; remaining bytes of that frame are treated as a new frame only after ss_s high (state forced to DRAIN if ss_s low when rst deasserts).
- SPI slave loads tx_data at the edge rx_valid rises; value written after rx_valid of byte k is shifted out during byte k+2. Read data ready 2 cycles after cmd rx_valid; requires SCK period >= 4 clk.
- reg_we: cycle after final-byte rx_valid. reg_rd: cycle after cmd rx_valid. reg_addr stable from cmd+1 until next frame's cmd.
- ss_s lags pin by 2 clk.

## Configuration
- SPI_FRAME_CHECKSUM_EN defined: write frame gains byte 5 = XOR of bytes 0-4; reg_we issued after byte 5 only if match, else crc_err set, no write. Write frame ending after byte 4 -> frame_err. Reads unchanged.
- Undefined: no WR_CRC state, write commits after byte 4, crc_err tied 0.

## Test plan
- Reset -> tx_data=0x25, all strobes 0, flags 0; write frame 0x85,0x12,0x34,0x56,0x78 -> single reg_we, reg_addr=0x05, reg_wdata=0x12345678.
- Read 0x03, reg_rdata=0xDEADBEEF -> reg_rd once, MISO bytes 0x25,0x25,0xDE,0xAD,0xBE,0xEF.
- Write 0x81,0xAA then ss high -> no reg_we, frame_err=1, next status byte 0xA5; err_clr -> 0x25.
- Write frame followed by 3 extra bytes -> exactly one reg_we, extra bytes ignored, no error.
- CHECKSUM_EN: 0x81,0x01,0x02,0x03,0x04,0x85 -> reg_we, wdata 0x01020304; last byte 0x00 -> no reg_we, crc_err=1.
- rst asserted after byte 2 of write frame -> no reg_we, remaining bytes of frame ignored; next full frame processed normally.

Source files
------------

// File: rtl/spi_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_decoder
// Purpose  : Turns the byte stream of one SPI slave-select assertion into a
//            register read or write on the stepper register bank, and keeps
//            the SPI slave's transmit byte loaded with status or read data.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            ss               - raw slave-select pin (active low, async)
//            rx_valid/rx_data - received byte strobe and value
//            tx_data          - byte loaded by the SPI slave at each rx_valid
//            reg_addr/reg_wdata/reg_we/reg_rd/reg_rdata - register bank side
//            err_clr          - clears the sticky error flags
//            frame_err        - sticky: a frame ended before completion
//            crc_err          - sticky: write checksum mismatch
// Options  : SPI_FRAME_CHECKSUM_EN - write frames carry a trailing XOR byte
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_decoder #(
  parameter int         ADDR_BITS = 7,
  parameter logic [5:0] STATUS_ID = 6'b100101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [7:0]           tx_data,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [31:0]          reg_wdata,
  output logic                 reg_we,
  output logic                 reg_rd,
  input  logic [31:0]          reg_rdata,
  input  logic                 err_clr,
  output logic                 frame_err,
  output logic                 crc_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_DATA  = 3'd1,
    S_WR_CRC   = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_DATA  = 3'd5,
    S_DRAIN    = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ss_meta;
  logic        r_ss_s;
  logic        r_rst_d;
  logic [2:0]  r_cnt;
  logic [23:0] r_wsh;
  logic [23:0] r_shadow;
  logic [31:0] w_wdata;
  logic [7:0]  w_status;
  logic        w_rx;
  logic        w_commit;
  logic        w_crc_bad;
  logic        w_short;

  // The synchroniser is deliberately left running through reset so that a
  // frame already in progress is still seen as "ss low" once reset ends.
  always_ff @(posedge clk) begin
    r_ss_meta <= ss;
    r_ss_s    <= r_ss_meta;
    r_rst_d   <= rst;
  end

  // Bytes only count while inside a frame and not on the first cycle after
  // reset (that cycle decides whether the rest of the frame is drained).
  assign w_rx     = rx_valid & ~r_ss_s & ~r_rst_d;
  assign w_status = {frame_err, crc_err, STATUS_ID};
  assign w_short  = r_ss_s & (r_state != S_IDLE) & (r_state != S_DRAIN);

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]  r_xor;
  logic [31:0] r_wpend;

  assign w_wdata = r_wpend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xor   <= 8'h00;
      r_wpend <= 32'h0;
      crc_err <= 1'b0;
    end else begin
      if (r_ss_s)
        r_xor <= 8'h00;
      else if (w_rx)
        r_xor <= r_xor ^ rx_data;
      if (r_state == S_WR_DATA && w_rx && r_cnt == 3'd4)
        r_wpend <= {r_wsh, rx_data};
      crc_err <= w_crc_bad | (crc_err & ~err_clr);
    end
  end
`else
  assign w_wdata = {r_wsh, rx_data};
  assign crc_err = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_crc_bad = 1'b0;
    if (r_ss_s) begin
      w_next = S_IDLE;
    end else if (r_rst_d) begin
      // Reset released mid-frame: ignore the rest of it.
      w_next = S_DRAIN;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx)
            w_next = rx_data[7] ? S_WR_DATA : S_RD_ISSUE;
        end
        S_WR_DATA: begin
          // r_cnt == 4 means this is the fourth data byte (D0).
          if (w_rx && r_cnt == 3'd4) begin
`ifdef SPI_FRAME_CHECKSUM_EN
            w_next = S_WR_CRC;
`else
            w_next   = S_DRAIN;
            w_commit = 1'b1;
`endif
          end
        end
`ifdef SPI_FRAME_CHECKSUM_EN
        S_WR_CRC: begin
          if (w_rx) begin
            w_next = S_DRAIN;
            if (rx_data == r_xor)
              w_commit = 1'b1;
            else
              w_crc_bad = 1'b1;
          end
        end
`endif
        S_RD_ISSUE: w_next = S_RD_WAIT;
        S_RD_WAIT:  w_next = S_RD_DATA;
        S_RD_DATA: begin
          if (w_rx && r_cnt == 3'd5)
            w_next = S_DRAIN;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_wsh     <= 24'h0;
      r_shadow  <= 24'h0;
      tx_data   <= {2'b00, STATUS_ID};
      reg_addr  <= '0;
      reg_wdata <= 32'h0;
      reg_we    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      reg_we    <= w_commit;
      reg_rd    <= (r_state == S_IDLE) && (w_next == S_RD_ISSUE);
      frame_err <= w_short | (frame_err & ~err_clr);

      if (r_ss_s)
        r_cnt <= 3'd0;
      else if (w_rx && r_cnt != 3'd7)
        r_cnt <= r_cnt + 3'd1;

      if (r_state == S_IDLE && w_rx)
        reg_addr <= ADDR_BITS'(rx_data[6:0]);
      if (r_state == S_WR_DATA && w_rx)
        r_wsh <= {r_wsh[15:0], rx_data};
      if (w_commit)
        reg_wdata <= w_wdata;
      if (r_state == S_RD_WAIT)
        r_shadow <= reg_rdata[23:0];

      // A byte written here is loaded by the slave at the next rx_valid and
      // shifted out during the byte after that.
      if (r_ss_s) begin
        tx_data <= w_status;
      end else begin
        case (r_state)
          S_RD_ISSUE: tx_data <= w_status;
          S_RD_WAIT:  tx_data <= reg_rdata[31:24];
          S_RD_DATA: begin
            if (w_rx) begin
              case (r_cnt)
                3'd1:    tx_data <= r_shadow[23:16];
                3'd2:    tx_data <= r_shadow[15:8];
                3'd3:    tx_data <= r_shadow[7:0];
                default: tx_data <= w_status;
              endcase
            end else if (r_cnt >= 3'd5) begin
              tx_data <= w_status;
            end
          end
          default: tx_data <= w_status;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_decoder
// Purpose  : Self-checking bench for spi_frame_decoder. Frames are described
//            as byte lists; expected register traffic, MISO bytes and flags
//            are derived from the frame-level rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_decoder;
  localparam int         ADDR_BITS = 7;
  localparam logic [5:0] ID        = 6'b100101;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ss = 1'b1;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic [7:0]           tx_data;
  logic [ADDR_BITS-1:0] reg_addr;
  logic [31:0]          reg_wdata;
  logic                 reg_we;
  logic                 reg_rd;
  logic [31:0]          reg_rdata = 32'h0;
  logic                 err_clr = 1'b0;
  logic                 frame_err;
  logic                 crc_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_we_cyc = -1;
  int          exp_rd_cyc = -1;
  logic [6:0]  exp_we_addr = 7'h0;
  logic [31:0] exp_we_data = 32'h0;
  logic [6:0]  exp_rd_addr = 7'h0;
  logic [31:0] rd_value = 32'h0;
  logic        use_fixed_rd = 1'b0;
  logic [31:0] fixed_rd = 32'h0;
  logic        chk_en = 1'b0;
  logic        idle_ok = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_cerr = 1'b0;
  int          we_seen = 0;
  int          rd_seen = 0;
  logic [6:0]  last_waddr = 7'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [7:0]  fb   [0:9];
  int          fn = 0;
  logic [7:0]  miso [0:10];

  spi_frame_decoder #(.ADDR_BITS(ADDR_BITS), .STATUS_ID(ID)) dut (
    .clk(clk), .rst(rst), .ss(ss), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .err_clr(err_clr), .frame_err(frame_err), .crc_err(crc_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register bank: read data valid only in the cycle after reg_rd.
  initial begin
    logic rd_pending;
    rd_pending = 1'b0;
    forever begin
      @(negedge clk);
      reg_rdata  = rd_pending ? rd_value : $urandom;
      rd_pending = reg_rd;
    end
  end

  // Per-cycle compare of strobes and idle status against the expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("reg_we", {31'h0, reg_we}, {31'h0, cyc == exp_we_cyc});
        chk("reg_rd", {31'h0, reg_rd}, {31'h0, cyc == exp_rd_cyc});
        if (reg_we) begin
          we_seen++;
          last_waddr = reg_addr;
          last_wdata = reg_wdata;
          chk("we_addr", {25'h0, reg_addr}, {25'h0, exp_we_addr});
          chk("we_data", reg_wdata, exp_we_data);
        end
        if (reg_rd) begin
          rd_seen++;
          chk("rd_addr", {25'h0, reg_addr}, {25'h0, exp_rd_addr});
        end
        if (idle_ok)
          chk("idle_status", {24'h0, tx_data}, {24'h0, m_ferr, m_cerr, ID});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit arm_we, input bit arm_rd,
                           output logic [7:0] seen_tx);
    repeat (33 + $urandom_range(0, 6)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    seen_tx  = tx_data;
    if (arm_we) exp_we_cyc = cyc + 1;
    if (arm_rd) exp_rd_cyc = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic clear_errors();
    idle_ok = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ferr  = 1'b0;
    m_cerr  = 1'b0;
    repeat (3) @(negedge clk);
    idle_ok = 1'b1;
  endtask

  // Runs the frame held in fb[0:fn-1] and checks its outcome.
  task automatic run_frame();
    logic [7:0] st, x, e;
    logic       wr, do_we, short_f, crc_bad;
    int         need, we0, rd0;
    st      = {m_ferr, m_cerr, ID};
    wr      = (fn > 0) && fb[0][7];
`ifdef SPI_FRAME_CHECKSUM_EN
    need    = 6;
`else
    need    = wr ? 5 : 6;
`endif
    short_f = (fn > 0) && (fn < need);
    do_we   = wr && (fn >= need);
    crc_bad = 1'b0;
    x       = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
`ifdef SPI_FRAME_CHECKSUM_EN
    if (do_we && fb[5] != x) begin
      do_we   = 1'b0;
      crc_bad = 1'b1;
    end
`endif
    if (fn > 0 && !wr) begin
      exp_rd_addr = fb[0][6:0];
      rd_value    = use_fixed_rd ? fixed_rd : $urandom;
    end
    if (do_we) begin
      exp_we_addr = fb[0][6:0];
      exp_we_data = {fb[1], fb[2], fb[3], fb[4]};
    end
    we0 = we_seen;
    rd0 = rd_seen;
    idle_ok = 1'b0;
    miso[0] = tx_data;
    ss = 1'b0;
    for (int k = 0; k < fn; k++)
      send_byte(fb[k], do_we && (k == need - 1), (k == 0) && !wr, miso[k+1]);
    repeat (20) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    if (short_f) m_ferr = 1'b1;
    if (crc_bad) m_cerr = 1'b1;
    for (int k = 0; k < fn; k++) begin
      if (wr || k < 2 || k > 5) e = st;
      else                      e = rd_value[8*(5-k) +: 8];
      chk("miso_byte", {24'h0, miso[k]}, {24'h0, e});
    end
    chk("frame_err", {31'h0, frame_err}, {31'h0, m_ferr});
    chk("crc_err", {31'h0, crc_err}, {31'h0, m_cerr});
    chk("we_count", we_seen - we0, do_we ? 1 : 0);
    chk("rd_count", rd_seen - rd0, (fn > 0 && !wr) ? 1 : 0);
    if (fn > 0) chk("addr_hold", {25'h0, reg_addr}, {25'h0, fb[0][6:0]});
    idle_ok = 1'b1;
  endtask

  initial begin
    logic [7:0] lit [0:5];
    logic [7:0] dummy;
    int         we0, n3;

    // Reset state
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", {24'h0, tx_data}, 32'h25);
    chk("rst_we", {31'h0, reg_we}, 32'h0);
    chk("rst_rd", {31'h0, reg_rd}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_cerr", {31'h0, crc_err}, 32'h0);
    chk("rst_addr", {25'h0, reg_addr}, 32'h0);
    chk("rst_wdata", reg_wdata, 32'h0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    idle_ok = 1'b1;

    // Basic write
    fb[0] = 8'h85; fb[1] = 8'h12; fb[2] = 8'h34; fb[3] = 8'h56; fb[4] = 8'h78;
    fn = 5;
`ifdef SPI_FRAME_CHECKSUM_EN
    fb[5] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
    fn = 6;
`endif
    we0 = we_seen;
    run_frame();
    chk("wr_lit_count", we_seen - we0, 1);
    chk("wr_lit_addr", {25'h0, last_waddr}, 32'h05);
    chk("wr_lit_data", last_wdata, 32'h12345678);

    // Read with fixed bank data
    use_fixed_rd = 1'b1;
    fixed_rd = 32'hDEADBEEF;
    fb[0] = 8'h03;
    for (int k = 1; k < 6; k++) fb[k] = 8'($urandom);
    fn = 6;
    run_frame();
    use_fixed_rd = 1'b0;
    lit[0] = 8'h25; lit[1] = 8'h25; lit[2] = 8'hDE;
    lit[3] = 8'hAD; lit[4] = 8'hBE; lit[5] = 8'hEF;
    for (int k = 0; k < 6; k++) chk("rd_lit_miso", {24'h0, miso[k]}, {24'h0, lit[k]});

    // Short write
    fb[0] = 8'h81; fb[1] = 8'hAA; fn = 2;
    run_frame();
    chk("short_ferr", {31'h0, frame_err}, 32'h1);
    chk("short_status", {24'h0, tx_data}, 32'hA5);
    clear_errors();
    chk("clr_status", {24'h0, tx_data}, 32'h25);

    // Write followed by extra bytes
    fb[0] = 8'h9A;
    for (int k = 1; k < 9; k++) fb[k] = 8'($urandom);
    fn = 8;
`ifdef SPI_FRAME_CHECKSUM_EN
    fb[5] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
    fn = 9;
`endif
    we0 = we_seen;
    run_frame();
    chk("extra_we_count", we_seen - we0, 1);

    // Error set coinciding with err_clr: set must win
    idle_ok = 1'b0;
    ss = 1'b0;
    send_byte(8'h81, 1'b0, 1'b0, dummy);
    repeat (20) @(negedge clk);
    ss = 1'b1;
    n3 = cyc + 2;
    while (cyc != n3) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("setwins_ferr", {31'h0, frame_err}, 32'h1);
    m_ferr = 1'b1;
    clear_errors();

    // Reset in the middle of a write frame
    idle_ok = 1'b0;
    we0 = we_seen;
    ss = 1'b0;
    send_byte(8'h85, 1'b0, 1'b0, dummy);
    send_byte(8'h12, 1'b0, 1'b0, dummy);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ferr = 1'b0;
    m_cerr = 1'b0;
    send_byte(8'h34, 1'b0, 1'b0, dummy);
    send_byte(8'h56, 1'b0, 1'b0, dummy);
    send_byte(8'h78, 1'b0, 1'b0, dummy);
`ifdef SPI_FRAME_CHECKSUM_EN
    send_byte(8'h00, 1'b0, 1'b0, dummy);
`endif
    repeat (20) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid_we", we_seen - we0, 0);
    chk("rstmid_ferr", {31'h0, frame_err}, 32'h0);
    chk("rstmid_addr", {25'h0, reg_addr}, 32'h0);
    idle_ok = 1'b1;
    fb[0] = 8'hC4; fb[1] = 8'hA1; fb[2] = 8'hB2; fb[3] = 8'hC3; fb[4] = 8'hD4;
    fn = 5;
`ifdef SPI_FRAME_CHECKSUM_EN
    fb[5] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
    fn = 6;
`endif
    run_frame();
    chk("after_rst_data", last_wdata, 32'hA1B2C3D4);

`ifdef SPI_FRAME_CHECKSUM_EN
    fb[0] = 8'h81; fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03; fb[4] = 8'h04;
    fb[5] = 8'h85; fn = 6;
    we0 = we_seen;
    run_frame();
    chk("crc_ok_count", we_seen - we0, 1);
    chk("crc_ok_data", last_wdata, 32'h01020304);
    fb[5] = 8'h00;
    run_frame();
    chk("crc_bad_count", we_seen - we0, 1);
    chk("crc_bad_flag", {31'h0, crc_err}, 32'h1);
    clear_errors();
`endif

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      fn = $urandom_range(0, 9);
      for (int k = 0; k < 10; k++) fb[k] = 8'($urandom);
`ifdef SPI_FRAME_CHECKSUM_EN
      if ($urandom_range(0, 1) == 1) fb[5] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
`endif
      run_frame();
      if ($urandom_range(0, 3) == 0) clear_errors();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
